soc_pad_input_sampler: RTL

//  Read side of the SoC pad ring: samples NB_PADS pad inputs (pads configured as input, with or without pull-up/down),

---
 rtl/soc_pad_pkg.sv | 9 +
 rtl/soc_pad_debounce.sv | 62 ++++++
 rtl/soc_pad_input_sampler.sv | 92 +++++++++
 3 files changed

// File: rtl/soc_pad_pkg.sv
// Shared register-map constants for the pad input sampler.
package soc_pad_pkg;

  localparam logic [1:0] REG_VALUE   = 2'd0;
  localparam logic [1:0] REG_RISE_EN = 2'd1;
  localparam logic [1:0] REG_FALL_EN = 2'd2;
  localparam logic [1:0] REG_PENDING = 2'd3;

endpackage

// File: rtl/soc_pad_debounce.sv
// One pad: 2-FF synchroniser, debounce counter, stable level and one-cycle rise/fall pulses.
// Stable follows the pad 2+DEBOUNCE_CYCLES edges after a change (3 edges in bypass); no backpressure.
module soc_pad_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic stable_q;
  logic accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= pad;
      sync_q <= meta_q;
    end
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign accept = (sync_q != stable_q);
  end else begin : g_cnt
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [CW-1:0] cnt;

    // Any return to the stable level restarts the count from zero.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt <= '0;
      end else if ((sync_q == stable_q) || (cnt == LAST)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end

    assign accept = (sync_q != stable_q) && (cnt == LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_q <= 1'b0;
    end else if (accept) begin
      stable_q <= sync_q;
    end
  end

  assign level = stable_q;
  assign rise  = accept & sync_q;
  assign fall  = accept & ~sync_q;

endmodule

// File: rtl/soc_pad_input_sampler.sv
// Pad-ring read side: debounced pad levels, edge-enable registers, sticky W1C pending flags and level irq.
// Bus ack and read data one cycle after bus_sel, back-to-back accesses accepted; no backpressure.
module soc_pad_input_sampler
  import soc_pad_pkg::*;
#(
  parameter int NB_PADS         = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NB_PADS-1:0] pad_in,
  input  logic               bus_sel,
  input  logic               bus_we,
  input  logic [1:0]         bus_addr,
  input  logic [31:0]        bus_wdata,
  output logic [31:0]        bus_rdata,
  output logic               bus_ack,
  output logic               irq
);

  logic [NB_PADS-1:0] stable;
  logic [NB_PADS-1:0] rise;
  logic [NB_PADS-1:0] fall;
  logic [NB_PADS-1:0] rise_en;
  logic [NB_PADS-1:0] fall_en;
  logic [NB_PADS-1:0] pending;
  logic [NB_PADS-1:0] pending_nxt;
  logic [NB_PADS-1:0] wdata;
  logic [NB_PADS-1:0] w1c;
  logic [31:0]        rd_mux;
  logic               wr;
  logic               rd;
  logic               wdata_unused;

  for (genvar i = 0; i < NB_PADS; i++) begin : g_pad
    soc_pad_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .pad  (pad_in[i]),
      .level(stable[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  assign wr           = bus_sel & bus_we;
  assign rd           = bus_sel & ~bus_we;
  assign wdata        = bus_wdata[NB_PADS-1:0];
  assign wdata_unused = ^bus_wdata;
  assign w1c          = (wr && (bus_addr == REG_PENDING)) ? wdata : '0;

  // New events are ORed in after the clear so a same-cycle set beats W1C.
  assign pending_nxt = (pending & ~w1c) | (rise & rise_en) | (fall & fall_en);

  always_comb begin
    rd_mux = '0;
    case (bus_addr)
      REG_VALUE:   rd_mux[NB_PADS-1:0] = stable;
      REG_RISE_EN: rd_mux[NB_PADS-1:0] = rise_en;
      REG_FALL_EN: rd_mux[NB_PADS-1:0] = fall_en;
      REG_PENDING: rd_mux[NB_PADS-1:0] = pending;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_en   <= '0;
      fall_en   <= '0;
      pending   <= '0;
      bus_rdata <= '0;
      bus_ack   <= 1'b0;
    end else begin
      bus_ack <= bus_sel;
      pending <= pending_nxt;
      if (wr && (bus_addr == REG_RISE_EN)) begin
        rise_en <= wdata;
      end
      if (wr && (bus_addr == REG_FALL_EN)) begin
        fall_en <= wdata;
      end
      if (rd) begin
        bus_rdata <= rd_mux;
      end
    end
  end

  assign irq = |pending;

endmodule
